regbank_write_arbiter: RTL and testbench

//   Shares the single write port of the 32x32 register bank (regbank_v4) between two requesters.
//   - Valid/ready handshake per requester; round-robin when both request.
//   - After reset, or on init_start, runs a clear sweep writing INIT_VAL to every register.
//   - Sits directly in front of regbank_v4: drives its write, dr and wrdata inputs.

---
 rtl/regbank_pkg.sv | 27 ++
 rtl/regbank_write_arbiter_rr_arb2.sv | 42 ++++
 rtl/regbank_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_regbank_write_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the regbank write-port arbiter: default sizes,
// FSM state encoding, requester index type and a saturating counter helper.
package regbank_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 32;

  // CLEAR sweeps INIT_VAL over the bank, RUN serves the two requesters.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Names one of the two requesters (0 or 1).
  typedef logic req_idx_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. An uncontested valid is granted
// directly; when both are valid the pointer picks the winner and then flips
// to the other requester. The pointer only moves on a contended grant.
module rr_arb2
  import regbank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] gnt
);

  req_idx_t r_ptr;

  // Grant decode from the valids and the priority pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (r_ptr == 1'b0) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Pointer hands priority to the loser after every contended grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (en && (valid == 2'b11)) begin
      r_ptr <= ~r_ptr;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: shares the single write port of the register bank
// between two valid/ready requesters. After reset or init_start it sweeps
// INIT_VAL into every register before serving requests again.
// Optional feature macro: REGBANK_ARB_STATS_EN adds per-requester
// saturating grant counters (gnt0_cnt, gnt1_cnt).
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                NREGS    = NREGS_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}},
  parameter bit                R0_RO    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              write,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] wrdata
`ifdef REGBANK_ARB_STATS_EN
  ,
  output logic [15:0]       gnt0_cnt,
  output logic [15:0]       gnt1_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_next_idx;
  logic              r_write;
  logic              w_next_write;
  logic [ADDR_W-1:0] r_dr;
  logic [ADDR_W-1:0] w_next_dr;
  logic [DATA_W-1:0] r_wrdata;
  logic [DATA_W-1:0] w_next_wrdata;
  logic              r_done;
  logic              w_next_done;

  logic              w_en;
  logic [1:0]        w_gnt;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_drop;

  // Requests are only served in RUN; init_start and reset close the port
  // in the same cycle so no handshake can slip past them.
  assign w_en = (r_state == ST_RUN) && !init_start && !reset;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .en    (w_en),
    .gnt   (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  assign w_gnt_addr = w_gnt[1] ? req1_addr : req0_addr;
  assign w_gnt_data = w_gnt[1] ? req1_data : req0_data;

  // A write to register 0 is consumed but not forwarded when it is read-only.
  assign w_drop = R0_RO && (w_gnt_addr == {ADDR_W{1'b0}});

  // Next-state and next-output logic for the CLEAR/RUN controller.
  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_idx;
    w_next_write  = 1'b0;
    w_next_dr     = r_dr;
    w_next_wrdata = r_wrdata;
    w_next_done   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_next_write  = 1'b1;
        w_next_dr     = r_idx;
        w_next_wrdata = INIT_VAL;
        if (r_idx == LAST_IDX) begin
          w_next_done  = 1'b1;
          w_next_state = ST_RUN;
          w_next_idx   = {ADDR_W{1'b0}};
        end else begin
          w_next_idx = r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        if (init_start) begin
          w_next_state = ST_CLEAR;
          w_next_idx   = {ADDR_W{1'b0}};
        end else if ((w_gnt != 2'b00) && !w_drop) begin
          w_next_write  = 1'b1;
          w_next_dr     = w_gnt_addr;
          w_next_wrdata = w_gnt_data;
        end else begin
          w_next_write = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_CLEAR;
        w_next_idx   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, sweep index and regbank-facing output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_CLEAR;
      r_idx    <= {ADDR_W{1'b0}};
      r_write  <= 1'b0;
      r_dr     <= {ADDR_W{1'b0}};
      r_wrdata <= {DATA_W{1'b0}};
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_next_idx;
      r_write  <= w_next_write;
      r_dr     <= w_next_dr;
      r_wrdata <= w_next_wrdata;
      r_done   <= w_next_done;
    end
  end

  assign write     = r_write;
  assign dr        = r_dr;
  assign wrdata    = r_wrdata;
  assign init_done = r_done;
  assign init_busy = (r_state == ST_CLEAR);

`ifdef REGBANK_ARB_STATS_EN
  logic [15:0] r_gnt0_cnt;
  logic [15:0] r_gnt1_cnt;

  // Accepted handshakes per requester; sweeps never grant, so never count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt0_cnt <= 16'd0;
      r_gnt1_cnt <= 16'd0;
    end else begin
      r_gnt0_cnt <= w_gnt[0] ? sat_inc16(r_gnt0_cnt) : r_gnt0_cnt;
      r_gnt1_cnt <= w_gnt[1] ? sat_inc16(r_gnt1_cnt) : r_gnt1_cnt;
    end
  end

  assign gnt0_cnt = r_gnt0_cnt;
  assign gnt1_cnt = r_gnt1_cnt;
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter: directed scenarios followed
// by randomized traffic, all checked against a behavioural model of the
// arbiter and of the register bank contents.
module tb_regbank_write_arbiter;

  localparam int          DW = 32;
  localparam int          AW = 5;
  localparam int          NR = 32;
  localparam logic [31:0] IV = 32'h0000_DEAD;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          init_start;
  logic          init_busy, init_done;
  logic          write;
  logic [AW-1:0] dr;
  logic [DW-1:0] wrdata;
`ifdef REGBANK_ARB_STATS_EN
  logic [15:0]   gnt0_cnt, gnt1_cnt;
`endif

  regbank_write_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NREGS    (NR),
    .INIT_VAL (IV),
    .R0_RO    (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .write      (write),
    .dr         (dr),
    .wrdata     (wrdata)
`ifdef REGBANK_ARB_STATS_EN
    ,
    .gnt0_cnt   (gnt0_cnt),
    .gnt1_cnt   (gnt1_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the register bank: commits on the edge after write is seen.
  logic [31:0] bank [NR];
  always @(posedge clk) begin
    if (write) bank[dr] <= wrdata;
  end

  // Reference model state.
  bit          m_clr;
  int          m_idx;
  int          m_turn;
  logic [31:0] m_mem [NR];
  logic        exp_write, exp_done;
  logic [31:0] exp_dr, exp_wd;
  logic        e_r0, e_r1;
  int          m_c0, m_c1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // One clock: predict and check readies, advance the model, check outputs.
  task automatic cycle();
    int          w;
    logic [31:0] a, d;
    w = -1;
    if (!reset && !m_clr && !init_start) begin
      if (req0_valid && req1_valid) begin
        w = m_turn;
        m_turn = 1 - m_turn;
      end else if (req0_valid) begin
        w = 0;
      end else if (req1_valid) begin
        w = 1;
      end
    end
    e_r0 = (w == 0);
    e_r1 = (w == 1);
    #1;
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    exp_done = 1'b0;
    if (reset) begin
      m_clr = 1'b1; m_idx = 0; m_turn = 0;
      exp_write = 1'b0; exp_dr = 0; exp_wd = 0;
      m_c0 = 0; m_c1 = 0;
    end else if (m_clr) begin
      exp_write = 1'b1; exp_dr = m_idx; exp_wd = IV;
      m_mem[m_idx] = IV;
      exp_done = (m_idx == NR - 1);
      m_idx++;
      if (m_idx == NR) begin
        m_clr = 1'b0;
        m_idx = 0;
      end
    end else if (init_start) begin
      exp_write = 1'b0; m_clr = 1'b1; m_idx = 0;
    end else if (w >= 0) begin
      a = (w == 1) ? 32'(req1_addr) : 32'(req0_addr);
      d = (w == 1) ? req1_data : req0_data;
      if (w == 0) m_c0 = (m_c0 < 65535) ? m_c0 + 1 : m_c0;
      else        m_c1 = (m_c1 < 65535) ? m_c1 + 1 : m_c1;
      if (a == 0) begin
        exp_write = 1'b0;
      end else begin
        exp_write = 1'b1; exp_dr = a; exp_wd = d; m_mem[a] = d;
      end
    end else begin
      exp_write = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("write", write, exp_write);
    chk("dr", dr, exp_dr);
    chk("wrdata", wrdata, exp_wd);
    chk("init_done", init_done, exp_done);
    chk("init_busy", init_busy, m_clr);
`ifdef REGBANK_ARB_STATS_EN
    chk("gnt0_cnt", gnt0_cnt, m_c0);
    chk("gnt1_cnt", gnt1_cnt, m_c1);
`endif
  endtask

  initial begin
    int k0, k1, guard;
    reset = 1'b1; init_start = 1'b0;
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // T1: two reset cycles, then a full clear sweep of INIT_VAL.
    cycle(); cycle();
    reset = 1'b0;
    repeat (NR) cycle();
    cycle();
    for (int i = 0; i < NR; i++) chk("t1_readback", bank[i], IV);

    // T2: single requester, register 5.
    set_req(1'b1, 5'd5, 32'd50, 1'b0, 5'd0, 32'd0);
    cycle();
    chk("t2_ready_now", req0_ready, 1'b1);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle();
    chk("t2_reg5", bank[5], 32'd50);

    // T3: both requesters contend; grants alternate, only winners advance.
    k0 = 1; k1 = 1; guard = 0;
    while ((k0 <= 4 || k1 <= 4) && guard < 20) begin
      set_req(k0 <= 4, AW'(k0), 32'(10 * k0), k1 <= 4, AW'(10 + k1), 32'(100 * k1));
      cycle();
      if (e_r0) k0++;
      if (e_r1) k1++;
      guard++;
    end
    chk("t3_cycles", guard, 32'd8);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      chk("t3_req0_reg", bank[k], 32'(10 * k));
      chk("t3_req1_reg", bank[10 + k], 32'(100 * k));
    end

    // T4: init_start beats a pending request; request served after the sweep.
    init_start = 1'b1;
    set_req(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd77);
    cycle();
    chk("t4_blocked", req1_ready, 1'b0);
    init_start = 1'b0;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!e_r1 && guard < 40);
    chk("t4_wait", guard, 32'(NR + 1));
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(); cycle();
    chk("t4_reg7", bank[7], 32'd77);

    // T5: write to read-only register 0 is consumed but dropped.
    set_req(1'b1, 5'd0, 32'd99, 1'b0, 5'd0, 32'd0);
    cycle();
    chk("t5_write", write, 1'b0);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle();
    chk("t5_reg0", bank[0], IV);

    // T6: reset in the middle of a sweep restarts it at register 0.
    init_start = 1'b1;
    cycle();
    init_start = 1'b0;
    repeat (12) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("t6_restart_dr", dr, 32'd0);
    repeat (NR - 1) cycle();

    // Randomized traffic with occasional sweeps and resets.
    for (int n = 0; n < 800; n++) begin
      if (!req0_valid || e_r0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_addr  = AW'($urandom_range(0, NR - 1));
        req0_data  = $urandom;
      end
      if (!req1_valid || e_r1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_addr  = AW'($urandom_range(0, NR - 1));
        req1_data  = $urandom;
      end
      init_start = ($urandom_range(0, 59) == 0);
      reset      = ($urandom_range(0, 249) == 0);
      cycle();
    end

    init_start = 1'b0; reset = 1'b0;
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (NR + 2) cycle();
    for (int i = 0; i < NR; i++) chk("final_readback", bank[i], m_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
